// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller and its byte buffer.
package uart_pkg;
  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_QUIESCE,
    ST_APPLY
  } state_t;

  localparam int              BAUD_W             = 3;
  localparam logic [BAUD_W-1:0] RESET_BAUD_DEFAULT = 3'd0;
  localparam logic [7:0]      CNT_MAX            = 8'hFF;
endpackage

// File: rtl/rx_byte_fifo.sv
// Show-ahead byte FIFO; read data valid combinationally while not empty, one-cycle write-to-read latency.
// Pushes when full are refused unless a pop happens in the same cycle.
module rx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the oldest entry leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/uart_rx_controller.sv
// Receiver supervisor: enable/baud-change sequencing, rx_valid edge capture, error counters, output FIFO.
// Bytes appear on out_data one clock after capture; out_ready backpressure fills the FIFO, then drops and flags overflow.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int                FIFO_DEPTH     = 4,
  parameter int                QUIESCE_CYCLES = 16,
  parameter logic [BAUD_W-1:0] RESET_BAUD     = RESET_BAUD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [BAUD_W-1:0] cfg_baud,
  input  logic              cfg_load,
  output logic              cfg_busy,
  output logic              rx_en,
  output logic [BAUD_W-1:0] baud_select,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferror,
  input  logic              rx_perror,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [7:0]        ferr_cnt,
  output logic [7:0]        perr_cnt,
  input  logic              err_clear
);
  localparam int               QW     = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
  localparam logic [QW-1:0]    Q_LOAD = QW'(QUIESCE_CYCLES - 1);

  state_t            state, next_state;
  logic [QW-1:0]     qcnt;
  logic [BAUD_W-1:0] baud_pend;
  logic              latch_baud, off_baud, apply_baud;
  logic              rx_valid_q;
  logic              byte_evt, push_req, pop, full, empty;

  always_comb begin
    next_state = state;
    latch_baud = 1'b0;
    off_baud   = 1'b0;
    apply_baud = 1'b0;
    case (state)
      ST_OFF: begin
        if (cfg_load)        off_baud   = 1'b1;
        else if (cfg_enable) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_enable) next_state = ST_OFF;
        else if (cfg_load) begin
          latch_baud = 1'b1;
          next_state = ST_QUIESCE;
        end
      end
      ST_QUIESCE: if (qcnt == '0) next_state = ST_APPLY;
      ST_APPLY: begin
        apply_baud = 1'b1;
        next_state = cfg_enable ? ST_RUN : ST_OFF;
      end
      default: next_state = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_OFF;
      qcnt        <= '0;
      baud_pend   <= RESET_BAUD;
      baud_select <= RESET_BAUD;
    end else begin
      state <= next_state;
      if (latch_baud) begin
        baud_pend <= cfg_baud;
        qcnt      <= Q_LOAD;
      end else if (state == ST_QUIESCE && qcnt != '0) begin
        qcnt <= qcnt - QW'(1);
      end
      if (off_baud)        baud_select <= cfg_baud;
      else if (apply_baud) baud_select <= baud_pend;
    end
  end

  assign rx_en    = (state == ST_RUN);
  assign cfg_busy = (state == ST_QUIESCE) || (state == ST_APPLY);

  // Receiver may hold Rx_VALID for several clocks; only its rising edge counts as a byte.
  always_ff @(posedge clk) begin
    if (reset) rx_valid_q <= 1'b0;
    else       rx_valid_q <= rx_valid;
  end

  assign byte_evt  = rx_valid && !rx_valid_q && (state == ST_RUN);
  assign push_req  = byte_evt && !rx_ferror && !rx_perror;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || err_clear) begin
      ferr_cnt <= '0;
      perr_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (byte_evt && rx_ferror && ferr_cnt != CNT_MAX) ferr_cnt <= ferr_cnt + 8'd1;
      if (byte_evt && rx_perror && perr_cnt != CNT_MAX) perr_cnt <= perr_cnt + 8'd1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (rx_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty)
  );
endmodule
